// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle in RUN,
// sign fix-up and HI/LO writeback in FIX. MTHI/MTLO write HI/LO directly.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic [1:0]         state;
  logic               is_div, neg_q, neg_r, div0;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   opb;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;   // mul: {partial, multiplier}; div: {rem, quotient}

  logic               accept, f_mul, f_div, f_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     msum, dshift, dtrial;
  logic [2*WIDTH-1:0] acc_next, prod_fix;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  assign busy     = (state != S_IDLE);
  assign accept   = start && !flush && (state == S_IDLE);
  assign f_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign f_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign f_signed = (funct == F_MULT) || (funct == F_DIV);
  assign abs_a    = (f_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign abs_b    = (f_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
  assign dshift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dtrial = dshift - {1'b0, opb};

  always_comb begin
    acc_next = {msum, acc[WIDTH-1:1]};
    if (is_div)
      acc_next = dtrial[WIDTH] ? {dshift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // On divide-by-zero the remainder is |a|; re-applying neg_r restores raw a.
  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  assign quo_fix  = div0 ? {WIDTH{1'b1}}
                  : (neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      cnt    <= '0;
      opb    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (funct == F_MTHI) hi <= a;
          else if (funct == F_MTLO) lo <= a;
          else if (f_mul || f_div) begin
            is_div <= f_div;
            neg_q  <= f_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= f_signed && a[WIDTH-1];
            div0   <= f_div && (b == '0);
            opb    <= f_div ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (f_div ? abs_a : abs_b)};
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) state <= S_IDLE;
          else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [5:0] funct = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [W-1:0] hi, lo;

  int n_chk = 0, n_pass = 0;
  logic [W-1:0] mhi = '0, mlo = '0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    rh = '0;
    rl = '0;
    if (f == F_MULT || f == F_MULTU) begin
      p  = (f == F_MULT) ? 64'(sx * sy) : ({32'b0, x} * {32'b0, y});
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == 0) begin
      rh = x;
      rl = '1;
    end else if (f == F_DIVU) begin
      rl = x / y;
      rh = x % y;
    end else begin
      rl = 32'(sx / sy);
      rh = 32'(sx % sy);
    end
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle so the
  // next op issues back-to-back. inj>0 fires a stray MTLO at that cycle.
  task automatic do_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input int inj);
    int n, bc;
    logic [31:0] eh, el;
    ref_op(f, x, y, eh, el);
    funct = f; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1; bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      a = $urandom; b = $urandom;
      if (n == inj) begin funct = F_MTLO; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", 64'(n), 64'd34);
    chk("busy_cycles", 64'(bc), 64'd33);
    chk("busy_in_done", 64'(busy), 64'd0);
    mhi = eh; mlo = el;
    chk("hi", 64'(hi), 64'(mhi));
    chk("lo", 64'(lo), 64'(mlo));
  endtask

  task automatic mt(input logic [5:0] f, input logic [31:0] x);
    funct = f; a = x; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (f == F_MTHI) mhi = x; else mlo = x;
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_done", 64'(done), 64'd0);
    chk("mt_hi", 64'(hi), 64'(mhi));
    chk("mt_lo", 64'(lo), 64'(mlo));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mt(F_MTHI, 32'hcafe_babe);
    mt(F_MTLO, 32'h1234_5678);

    // unknown funct and flush-suppressed start leave everything alone
    funct = 6'b100000; a = 32'h0000_ffff; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_funct_busy", 64'(busy), 64'd0);
    chk("bad_funct_hi", 64'(hi), 64'(mhi));
    funct = F_MTHI; a = 32'h1111_1111; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_hi", 64'(hi), 64'(mhi));
    chk("idle_flush_busy", 64'(busy), 64'd0);

    do_op(F_MULTU, 32'hffff_ffff, 32'hffff_ffff, 0);
    chk("multu_max_hi", 64'(hi), 64'h0000_0000_ffff_fffe);
    do_op(F_MULT,  32'hffff_fffd, 32'd7, 0);
    do_op(F_MULT,  32'h8000_0000, 32'h8000_0000, 0);
    do_op(F_DIV,   32'hffff_fff9, 32'd2, 0);
    do_op(F_DIVU,  32'd100, 32'd7, 0);
    do_op(F_DIV,   32'h8000_0000, 32'hffff_ffff, 0);
    do_op(F_DIVU,  32'h0000_1234, 32'd0, 0);
    do_op(F_DIV,   32'hffff_fff0, 32'd0, 0);
    do_op(F_DIV,   32'd1000, 32'hffff_fffd, 15);
    do_op(F_MULTU, 32'd12345, 32'd6789, 0);
    idle_cycle();

    for (int i = 0; i < 30; i++) begin
      do_op(F_MULT + 6'($urandom_range(0, 3)), rnd_val(), rnd_val(), 0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();

    // flush mid-RUN: no done, HI/LO kept
    funct = F_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hi", 64'(hi), 64'(mhi));
    chk("flush_lo", 64'(lo), 64'(mlo));

    // asynchronous reset mid-RUN
    funct = F_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    mhi = '0; mlo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    do_op(F_DIVU, 32'd100, 32'd7, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage. It owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle). It also executes the single-cycle MTHI/MTLO writes. It reports busy so the hazard unit can stall EX, and it exposes HI/LO continuously for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width and HI/LO width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  issue strobe from EX; sampled only when busy=0
funct  input  6  R-type funct of issued instruction
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  abort the in-flight operation (branch or exception squash)
busy  output  1  high while an iterative operation is in flight
done  output  1  one-cycle pulse when HI/LO take a new mul/div result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all internal operand registers cleared.
- Decoded funct values: 011000 MULT (signed), 011001 MULTU, 011010 DIV (signed), 011011 DIVU, 010001 MTHI, 010011 MTLO. Any other funct with start=1 is ignored, with no state change.
- States: IDLE, RUN, FIX.
- IDLE:
  - start with MTHI: hi<=a at the edge. No busy, no done.
  - start with MTLO: lo<=a at the edge. No busy, no done.
  - start with a mul/div funct: latch the op type. For signed ops, latch |a| and |b| plus sign flags neg_q=a[W-1]^b[W-1] and neg_r=a[W-1]; for unsigned ops, latch raw operands with both flags 0. Clear the accumulator and counter, then go to RUN. busy goes high in the next cycle.
- RUN:
  - Exactly WIDTH cycles, one iteration per cycle; the counter counts 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring divide with a WIDTH+1-bit trial subtract; the quotient bit is shifted into the low register.
  - After the iteration with counter=WIDTH-1, go to FIX.
- FIX (one cycle):
  - Multiply: if neg_q, negate the 2*WIDTH product.
  - Divide: if neg_q, negate the quotient; if neg_r, negate the remainder.
  - Write hi and lo at the FIX->IDLE edge. Multiply: hi=product[2W-1:W], lo=product[W-1:0]. Divide: hi=remainder, lo=quotient.
  - done=1 for exactly the first IDLE cycle after FIX.
- Latency: start edge to done-high cycle is WIDTH+2 cycles (34 at default).
  - busy is high for WIDTH+1 cycles: all RUN cycles plus the FIX cycle.
  - busy is low in the done cycle, so a new start may be issued in the done cycle.
- Divide by zero (b=0, signed or unsigned): no trap. Result is lo=all ones and hi=a (raw, un-negated dividend). The FIX sign correction is bypassed for this case.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude algorithm and needs no special case.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit stalls on busy; the block itself never queues.
- flush:
  - In RUN or FIX: return to IDLE next cycle with busy=0 and no done. hi/lo are unchanged.
  - In IDLE: a same-cycle start is suppressed.
  - flush has priority over start.
- Reset mid-operation: immediate return to the reset state; a partial result is never written.
- hi/lo change only on MTHI/MTLO, on the FIX->IDLE edge, or on reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done pulses 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV a=0xFFFFFFF0, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF0.
- MTHI a=0xCAFEBABE while idle -> hi updates next edge, busy/done stay 0. A second start (MTLO) issued mid-DIV is ignored, so lo ends equal to the quotient. A back-to-back MULTU issued in the done cycle is accepted.
- Start DIVU 100/7, assert flush on cycle 10 -> busy drops next cycle, no done, hi/lo retain prior values. Repeat with rst_n pulsed low on cycle 20 -> hi=lo=0, IDLE, busy=0 asynchronously.
